// File: rtl/glitch_burst_gen.sv
// Trigger-driven glitch burst generator: after an armed trigger edge and a
// programmable delay, emits count pulses of programmable width and gap.
module glitch_burst_gen #(
    parameter int CNT_W = 32,
    parameter int NP_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             trig_edge,
    input  logic             arm,
    input  logic             abort,
    input  logic [CNT_W-1:0] delay_cfg,
    input  logic [CNT_W-1:0] width_cfg,
    input  logic [CNT_W-1:0] gap_cfg,
    input  logic [NP_W-1:0]  count_cfg,
    output logic             glitch,
    output logic             armed_indicator,
    output logic             delay_indicator,
    output logic             done_indicator,
    output logic [NP_W-1:0]  pulse_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NP_W-1:0]   pulse_idx_q, pulse_idx_d;
    logic [CNT_W-1:0]  delay_q, delay_d;
    logic [CNT_W-1:0]  width_q, width_d;
    logic [CNT_W-1:0]  gap_q, gap_d;
    logic [NP_W-1:0]   count_q, count_d;
    logic              edge_q, edge_d;
    logic              sync1_q, sync2_q, hist_q;
    logic              glitch_q, glitch_d;
    logic              armed_q, armed_d;
    logic              delay_ind_q, delay_ind_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  width_eff;
    logic [CNT_W-1:0]  gap_eff;
    logic [NP_W-1:0]   count_last;
    logic              edge_evt;

    // Zero-valued width/gap/count configurations behave as one.
    assign width_eff  = (width_q == '0) ? CNT_W'(1) : width_q;
    assign gap_eff    = (gap_q   == '0) ? CNT_W'(1) : gap_q;
    assign count_last = (count_q == '0) ? '0 : count_q - NP_W'(1);
    assign edge_evt   = (sync2_q != hist_q) && (sync2_q == edge_q);

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_idx_d = pulse_idx_q;
        delay_d     = delay_q;
        width_d     = width_q;
        gap_d       = gap_q;
        count_d     = count_q;
        edge_d      = edge_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        delay_d     = delay_cfg;
                        width_d     = width_cfg;
                        gap_d       = gap_cfg;
                        count_d     = count_cfg;
                        edge_d      = trig_edge;
                        pulse_idx_d = '0;
                        state_d     = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (edge_evt) begin
                        cnt_d   = CNT_W'(1);
                        state_d = (delay_q != '0) ? S_DELAY : S_PULSE;
                    end
                end
                // Counters run 1..cfg and reload on exit, so they never wrap.
                S_DELAY: begin
                    if (cnt_q == delay_q) begin
                        cnt_d   = CNT_W'(1);
                        state_d = S_PULSE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_PULSE: begin
                    if (cnt_q == width_eff) begin
                        cnt_d   = CNT_W'(1);
                        state_d = (pulse_idx_q == count_last) ? S_DONE : S_GAP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == gap_eff) begin
                        cnt_d       = CNT_W'(1);
                        pulse_idx_d = pulse_idx_q + NP_W'(1);
                        state_d     = S_PULSE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        glitch_d    = (state_d == S_PULSE);
        armed_d     = (state_d == S_ARMED);
        delay_ind_d = (state_d == S_DELAY);
        done_d      = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pulse_idx_q <= '0;
            delay_q     <= '0;
            width_q     <= '0;
            gap_q       <= '0;
            count_q     <= '0;
            edge_q      <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            hist_q      <= 1'b0;
            glitch_q    <= 1'b0;
            armed_q     <= 1'b0;
            delay_ind_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_idx_q <= pulse_idx_d;
            delay_q     <= delay_d;
            width_q     <= width_d;
            gap_q       <= gap_d;
            count_q     <= count_d;
            edge_q      <= edge_d;
            sync1_q     <= trigger;
            sync2_q     <= sync1_q;
            hist_q      <= sync2_q;
            glitch_q    <= glitch_d;
            armed_q     <= armed_d;
            delay_ind_q <= delay_ind_d;
            done_q      <= done_d;
        end
    end

    assign glitch          = glitch_q;
    assign armed_indicator = armed_q;
    assign delay_indicator = delay_ind_q;
    assign done_indicator  = done_q;
    assign pulse_idx       = pulse_idx_q;

endmodule

// File: tb/tb_glitch_burst_gen.sv
// Self-checking bench: directed scenarios plus random traffic compared each
// cycle against a timeline model of the burst (delay, then N x (width+gap)).
module tb_glitch_burst_gen;

    localparam int CNT_W = 32;
    localparam int NP_W  = 8;

    logic             clk = 1'b0;
    logic             rst, trigger, trig_edge, arm, abort;
    logic [CNT_W-1:0] delay_cfg, width_cfg, gap_cfg;
    logic [NP_W-1:0]  count_cfg;
    logic             glitch, armed_indicator, delay_indicator, done_indicator;
    logic [NP_W-1:0]  pulse_idx;

    always #5 clk = ~clk;

    glitch_burst_gen #(.CNT_W(CNT_W), .NP_W(NP_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .trigger         (trigger),
        .trig_edge       (trig_edge),
        .arm             (arm),
        .abort           (abort),
        .delay_cfg       (delay_cfg),
        .width_cfg       (width_cfg),
        .gap_cfg         (gap_cfg),
        .count_cfg       (count_cfg),
        .glitch          (glitch),
        .armed_indicator (armed_indicator),
        .delay_indicator (delay_indicator),
        .done_indicator  (done_indicator),
        .pulse_idx       (pulse_idx)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Reference model: a burst is a timeline anchored at the edge where the
    // trigger event is seen; outputs at any cycle follow by arithmetic.
    typedef enum {M_IDLE, M_ARMED, M_RUN} mmode_t;
    mmode_t m_mode  = M_IDLE;
    int     m_d = 0, m_w = 1, m_g = 1, m_n = 1, m_start = 0, m_idx = 0;
    bit     m_edge = 1'b0;
    bit     p0 = 0, p1 = 0, p2 = 0;   // trigger as seen 1, 2, 3 edges ago
    int     gl_cnt = 0, dl_cnt = 0;

    function automatic int total_len();
        return m_d + m_n * m_w + (m_n - 1) * m_g;
    endfunction

    task automatic step();
        bit t_rst, t_abort, t_arm, t_trig, t_edge, evt, was_done;
        int t_d, t_w, t_g, t_n, prev, rel, r, k, m;
        bit e_gl, e_ar, e_dl, e_dn;
        t_rst = rst; t_abort = abort; t_arm = arm; t_trig = trigger; t_edge = trig_edge;
        t_d = int'(delay_cfg); t_w = int'(width_cfg); t_g = int'(gap_cfg); t_n = int'(count_cfg);
        @(posedge clk);
        prev = cyc;
        cyc++;
        was_done = (m_mode == M_RUN) && (prev - m_start >= total_len());
        evt = (p1 != p2) && (p1 == m_edge);
        if (t_rst) begin
            p0 = 0; p1 = 0; p2 = 0;
            m_mode = M_IDLE; m_idx = 0;
            m_d = 0; m_w = 1; m_g = 1; m_n = 1; m_edge = 0;
        end else begin
            p2 = p1; p1 = p0; p0 = t_trig;
            if (t_abort) begin
                m_mode = M_IDLE;
            end else if ((m_mode == M_IDLE || was_done) && t_arm) begin
                m_d = t_d;
                m_w = (t_w == 0) ? 1 : t_w;
                m_g = (t_g == 0) ? 1 : t_g;
                m_n = (t_n == 0) ? 1 : t_n;
                m_edge = t_edge;
                m_idx = 0;
                m_mode = M_ARMED;
            end else if (m_mode == M_ARMED && evt) begin
                m_mode = M_RUN;
                m_start = cyc;
            end
        end
        e_gl = 0; e_ar = 0; e_dl = 0; e_dn = 0;
        if (m_mode == M_ARMED) e_ar = 1;
        if (m_mode == M_RUN) begin
            rel = cyc - m_start;
            if (rel < m_d) begin
                e_dl = 1;
                m_idx = 0;
            end else begin
                r = rel - m_d;
                k = r / (m_w + m_g);
                m = r % (m_w + m_g);
                if (k >= m_n || (k == m_n - 1 && m >= m_w)) begin
                    e_dn = 1;
                    m_idx = m_n - 1;
                end else begin
                    e_gl = (m < m_w);
                    m_idx = k;
                end
            end
        end
        #1;
        check("glitch", 32'(glitch), 32'(e_gl));
        check("armed_indicator", 32'(armed_indicator), 32'(e_ar));
        check("delay_indicator", 32'(delay_indicator), 32'(e_dl));
        check("done_indicator", 32'(done_indicator), 32'(e_dn));
        check("pulse_idx", 32'(pulse_idx), 32'(m_idx));
        gl_cnt += int'(glitch);
        dl_cnt += int'(delay_indicator);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_arm(input bit e, input int d, input int w, input int g, input int n);
        trig_edge = e;
        delay_cfg = CNT_W'(d); width_cfg = CNT_W'(w); gap_cfg = CNT_W'(g); count_cfg = NP_W'(n);
        arm = 1; step(); arm = 0; step();
    endtask

    initial begin
        rst = 1; trigger = 0; trig_edge = 0; arm = 0; abort = 0;
        delay_cfg = '0; width_cfg = '0; gap_cfg = '0; count_cfg = '0;
        run(3);
        rst = 0;
        run(2);

        // Single pulse after a 10-cycle delay.
        do_arm(1, 10, 3, 7, 1);
        gl_cnt = 0; dl_cnt = 0;
        trigger = 1; run(20);
        check("req034_glitch_len", 32'(gl_cnt), 32'd3);
        check("req034_delay_len", 32'(dl_cnt), 32'd10);
        check("req034_done", 32'(done_indicator), 32'd1);
        trigger = 0; run(5);

        // Three-pulse burst with no delay.
        do_arm(1, 0, 2, 4, 3);
        gl_cnt = 0;
        trigger = 1; run(22);
        check("req035_glitch_total", 32'(gl_cnt), 32'd6);
        check("req035_last_idx", 32'(pulse_idx), 32'd2);
        trigger = 0; run(5);

        // Falling-edge arming with zero width/count.
        do_arm(0, 0, 0, 0, 0);
        gl_cnt = 0;
        trigger = 1; run(8);
        check("req036_wrong_edge", 32'(gl_cnt), 32'd0);
        trigger = 0; run(8);
        check("req036_one_pulse", 32'(gl_cnt), 32'd1);

        // Abort during the second pulse, then try to retrigger.
        do_arm(1, 2, 3, 2, 4);
        trigger = 1; run(11);
        check("req037_in_pulse1", 32'(glitch), 32'd1);
        abort = 1; step(); abort = 0;
        check("req037_abort_glitch", 32'(glitch), 32'd0);
        trigger = 0; run(3);
        gl_cnt = 0;
        trigger = 1; run(10);
        check("req037_ignored", 32'(gl_cnt), 32'd0);
        trigger = 0; run(4);

        // Arm during DELAY is ignored; then reset mid-DELAY.
        do_arm(1, 20, 2, 1, 1);
        trigger = 1; run(5);
        gl_cnt = 0;
        do_arm(1, 1, 9, 1, 1);
        run(25);
        check("req038_old_width", 32'(gl_cnt), 32'd2);
        trigger = 0; run(4);
        do_arm(1, 20, 2, 1, 1);
        trigger = 1; run(6);
        rst = 1; step(); rst = 0;
        check("req038_rst_delay", 32'(delay_indicator), 32'd0);
        trigger = 0; run(5);

        // Re-arm from DONE with a new width.
        do_arm(1, 0, 3, 1, 1);
        trigger = 1; run(8);
        trigger = 0; run(4);
        do_arm(1, 0, 5, 1, 1);
        gl_cnt = 0;
        trigger = 1; run(10);
        check("req039_new_width", 32'(gl_cnt), 32'd5);
        trigger = 0; run(4);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            abort = ($urandom_range(0, 59) == 0);
            arm   = ($urandom_range(0, 24) == 0);
            if (arm) begin
                trig_edge = 1'($urandom_range(0, 1));
                delay_cfg = CNT_W'($urandom_range(0, 6));
                width_cfg = CNT_W'($urandom_range(0, 4));
                gap_cfg   = CNT_W'($urandom_range(0, 4));
                count_cfg = NP_W'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 7) == 0) trigger = ~trigger;
            step();
        end
        rst = 0; abort = 0; arm = 0;
        run(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
